cache_req_driver: RTL and testbench

//  CPU-side request initiator for the cache's processor port: replays a loadable table of read/write

---
 rtl/cache_req_driver_pkg.sv | 26 ++
 rtl/cache_req_driver_if.sv | 23 ++
 rtl/cache_req_table.sv | 23 ++
 rtl/cache_req_driver.sv | 229 ++++++++++++++++++++++
 tb/tb_cache_req_driver.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_req_driver_pkg.sv
// Shared types for the cache request driver and the cache bench.
// Holds FSM states, request opcodes and the request-table entry layout.
package cache_req_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_GAP  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } drv_state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  // Table entry, packed MSB first as {op, addr, data}.
  typedef struct packed {
    logic                  op;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] data;
  } req_entry_t;

endpackage

// File: rtl/cache_req_driver_if.sv
// Processor-side cache port: request strobes out, busywait and data back.
// master = request initiator (CPU / driver), slave = cache.
interface cache_req_driver_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              c_read_i;
  logic              c_wr_i;
  logic [DATA_W-1:0] wr_data;
  logic              c_busywait_o;
  logic [DATA_W-1:0] c_data_o;

  modport master (
    output address, c_read_i, c_wr_i, wr_data,
    input  c_busywait_o, c_data_o
  );

  modport slave (
    input  address, c_read_i, c_wr_i, wr_data,
    output c_busywait_o, c_data_o
  );
endinterface

// File: rtl/cache_req_table.sv
// Request table: N_REQ x ENT_W register file, one write port, async read.
// Ports: clk, i_we/i_widx/i_wdata write side, i_ridx -> o_rdata read side.
module cache_req_table #(
  parameter int N_REQ = 8,
  parameter int IDX_W = 3,
  parameter int ENT_W = 65
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [ENT_W-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [ENT_W-1:0] o_rdata
);
  // Contents deliberately survive reset so a table can be replayed.
  logic [ENT_W-1:0] r_mem [N_REQ];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_widx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_ridx];
endmodule

// File: rtl/cache_req_driver.sv
// Replays a request table into the cache port, checks read data, counts stalls.
// Ports: clk/reset, cfg_* table load, start, bus (master), busy/done/error/counters.
module cache_req_driver
  import cache_req_driver_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_REQ   = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_op,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [IDX_W:0]    cfg_count,
  input  logic              start,
  cache_req_driver_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        mismatch_cnt,
  output logic [31:0]       stall_cycles
);
  localparam int ENT_W  = 1 + ADDR_W + DATA_W;
  localparam int CNT_W  = IDX_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(N_REQ);

  drv_state_e        r_state, w_nxt_state;
  logic [IDX_W-1:0]  r_idx, w_nxt_idx;
  logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
  logic              r_first, w_nxt_first;
  logic [WAIT_W-1:0] r_wait, w_nxt_wait;
  logic [ADDR_W-1:0] r_addr, w_nxt_addr;
  logic              r_rd, w_nxt_rd;
  logic              r_wr, w_nxt_wr;
  logic [DATA_W-1:0] r_wdata, w_nxt_wdata;
  logic              r_busy, w_nxt_busy;
  logic              r_done, w_nxt_done;
  logic              r_err, w_nxt_err;
  logic [7:0]        r_mm, w_nxt_mm;
  logic [31:0]       r_stall, w_nxt_stall;

  logic [ENT_W-1:0]  w_ent;
  logic [IDX_W-1:0]  w_ridx;
  logic              w_ent_op;
  logic [ADDR_W-1:0] w_ent_addr;
  logic [DATA_W-1:0] w_ent_data;
  logic [CNT_W-1:0]  w_cnt_clamp;
  logic [CNT_W-1:0]  w_last_idx;
  logic              w_is_last;
  logic              w_tbl_we;

  assign w_tbl_we = cfg_we && !reset && (r_state == ST_IDLE);
  assign w_ridx   = (r_state == ST_IDLE) ? '0 : r_idx;

  cache_req_table #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W),
    .ENT_W (ENT_W)
  ) u_table (
    .clk     (clk),
    .i_we    (w_tbl_we),
    .i_widx  (cfg_idx),
    .i_wdata ({cfg_op, cfg_addr, cfg_data}),
    .i_ridx  (w_ridx),
    .o_rdata (w_ent)
  );

  assign w_ent_op   = w_ent[ENT_W-1];
  assign w_ent_addr = w_ent[ADDR_W+DATA_W-1:DATA_W];
  assign w_ent_data = w_ent[DATA_W-1:0];

  // Out-of-range counts are clamped so the last-entry test always hits.
  assign w_cnt_clamp = (cfg_count > CNT_MAX) ? CNT_MAX : cfg_count;
  assign w_last_idx  = r_cnt - 1'b1;
  assign w_is_last   = ({1'b0, r_idx} == w_last_idx);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_cnt   = r_cnt;
    w_nxt_first = 1'b0;
    w_nxt_wait  = r_wait;
    w_nxt_addr  = '0;
    w_nxt_rd    = 1'b0;
    w_nxt_wr    = 1'b0;
    w_nxt_wdata = '0;
    w_nxt_busy  = r_busy;
    w_nxt_done  = 1'b0;
    w_nxt_err   = r_err;
    w_nxt_mm    = r_mm;
    w_nxt_stall = r_stall;
    unique case (r_state)
      ST_IDLE: begin
        w_nxt_busy = 1'b0;
        if (start) begin
          w_nxt_idx   = '0;
          w_nxt_cnt   = w_cnt_clamp;
          w_nxt_mm    = '0;
          w_nxt_stall = '0;
          w_nxt_err   = 1'b0;
          if (cfg_count == '0) begin
            w_nxt_state = ST_DONE;
            w_nxt_done  = 1'b1;
          end else begin
            w_nxt_state = ST_REQ;
            w_nxt_busy  = 1'b1;
            w_nxt_first = 1'b1;
            w_nxt_wait  = '0;
            w_nxt_addr  = w_ent_addr;
            w_nxt_rd    = (w_ent_op == OP_READ);
            w_nxt_wr    = (w_ent_op == OP_WRITE);
            w_nxt_wdata = (w_ent_op == OP_WRITE) ? w_ent_data : '0;
          end
        end
      end
      ST_REQ: begin
        w_nxt_addr  = r_addr;
        w_nxt_rd    = r_rd;
        w_nxt_wr    = r_wr;
        w_nxt_wdata = r_wdata;
        if (bus.c_busywait_o) begin
          if (r_stall != '1) w_nxt_stall = r_stall + 32'd1;
          if (r_wait == WAIT_LAST) begin
            w_nxt_state = ST_ERR;
            w_nxt_err   = 1'b1;
            w_nxt_busy  = 1'b0;
            w_nxt_addr  = '0;
            w_nxt_rd    = 1'b0;
            w_nxt_wr    = 1'b0;
            w_nxt_wdata = '0;
          end else begin
            w_nxt_wait = r_wait + 1'b1;
          end
        end else if (!r_first) begin
          // The cache may raise busywait one cycle late, so the
          // entry edge is skipped and only later idle edges complete.
          if (r_rd && (bus.c_data_o != w_ent_data) && (r_mm != '1))
            w_nxt_mm = r_mm + 8'd1;
          w_nxt_addr  = '0;
          w_nxt_rd    = 1'b0;
          w_nxt_wr    = 1'b0;
          w_nxt_wdata = '0;
          if (w_is_last) begin
            w_nxt_state = ST_DONE;
            w_nxt_done  = 1'b1;
            w_nxt_busy  = 1'b0;
          end else begin
            w_nxt_state = ST_GAP;
            w_nxt_idx   = r_idx + 1'b1;
          end
        end
      end
      ST_GAP: begin
        w_nxt_state = ST_REQ;
        w_nxt_first = 1'b1;
        w_nxt_wait  = '0;
        w_nxt_addr  = w_ent_addr;
        w_nxt_rd    = (w_ent_op == OP_READ);
        w_nxt_wr    = (w_ent_op == OP_WRITE);
        w_nxt_wdata = (w_ent_op == OP_WRITE) ? w_ent_data : '0;
      end
      ST_DONE: begin
        w_nxt_state = ST_IDLE;
        w_nxt_busy  = 1'b0;
      end
      ST_ERR: begin
        w_nxt_state = ST_IDLE;
        w_nxt_busy  = 1'b0;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_wait  <= '0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_mm    <= '0;
      r_stall <= '0;
    end else begin
      r_idx   <= w_nxt_idx;
      r_cnt   <= w_nxt_cnt;
      r_first <= w_nxt_first;
      r_wait  <= w_nxt_wait;
      r_addr  <= w_nxt_addr;
      r_rd    <= w_nxt_rd;
      r_wr    <= w_nxt_wr;
      r_wdata <= w_nxt_wdata;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
      r_err   <= w_nxt_err;
      r_mm    <= w_nxt_mm;
      r_stall <= w_nxt_stall;
    end
  end

  assign bus.address   = r_addr;
  assign bus.c_read_i  = r_rd;
  assign bus.c_wr_i    = r_wr;
  assign bus.wr_data   = r_wdata;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_err;
  assign mismatch_cnt  = r_mm;
  assign stall_cycles  = r_stall;
endmodule

// File: tb/tb_cache_req_driver.sv
// Bench for cache_req_driver: behavioural cache responder plus a table-level
// reference model of request order, durations, gaps, stalls and mismatches.
module tb_cache_req_driver;
  import cache_req_driver_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int IW = 3;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic          cfg_op = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic [IW:0]   cfg_count = '0;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [7:0]    mismatch_cnt;
  logic [31:0]   stall_cycles;

  cache_req_driver_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cache_req_driver #(
    .ADDR_W(AW), .DATA_W(DW), .N_REQ(NR), .IDX_W(IW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_op(cfg_op),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count),
    .start(start), .bus(bus),
    .busy(busy), .done(done), .error(error),
    .mismatch_cnt(mismatch_cnt), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory: cache contents and model copy
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] mdl_mem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    if (mdl_mem.exists(a)) return mdl_mem[a];
    return init_val(a);
  endfunction

  // ---------------- cache responder
  int lat_q[$];
  bit early_q[$];
  bit stuck = 1'b0;
  int r_cyc = 0;
  bit r_act = 1'b0;
  int r_l = 0;
  bit r_early = 1'b0;
  bit r_bz;

  always @(negedge clk) begin
    if (!(bus.c_read_i || bus.c_wr_i)) begin
      r_act = 1'b0;
      bus.c_busywait_o = 1'b0;
      bus.c_data_o = '0;
    end else begin
      if (!r_act) begin
        r_act = 1'b1;
        r_cyc = 0;
        if (lat_q.size() > 0) begin
          r_l = lat_q.pop_front();
          r_early = early_q.pop_front();
        end else begin
          r_l = 0;
          r_early = 1'b0;
        end
      end else begin
        r_cyc++;
      end
      r_bz = stuck || ((r_cyc == 0) ? r_early : (r_cyc <= r_l));
      bus.c_busywait_o = r_bz;
      bus.c_data_o = env_rd(bus.address);
      if (!r_bz && r_cyc >= 1 && bus.c_wr_i)
        env_mem[bus.address] = bus.wr_data;
    end
  end

  // ---------------- bus monitor
  typedef struct {
    bit          op;
    logic [31:0] addr;
    logic [31:0] data;
    int          dur;
  } txn_t;

  txn_t obs_q[$];
  int   gap_q[$];
  txn_t m_cur;
  int   m_gap = 0;
  bit   m_prev = 1'b0;
  bit   m_seen = 1'b0;
  bit   m_s;
  int   viol = 0;
  int   done_cnt = 0;

  always @(negedge clk) begin
    m_s = bus.c_read_i || bus.c_wr_i;
    if (bus.c_read_i && bus.c_wr_i) viol++;
    if (m_s && !busy) viol++;
    if (done && busy) viol++;
    if (done) done_cnt++;
    if (m_s) begin
      if (!m_prev) begin
        if (m_seen) gap_q.push_back(m_gap);
        m_cur.op = bus.c_wr_i;
        m_cur.addr = bus.address;
        m_cur.data = bus.c_wr_i ? bus.wr_data : '0;
        m_cur.dur = 1;
      end else begin
        m_cur.dur++;
        if (bus.address !== m_cur.addr || bus.c_wr_i !== m_cur.op ||
            (m_cur.op && bus.wr_data !== m_cur.data))
          viol++;
      end
    end else begin
      if (m_prev) begin
        obs_q.push_back(m_cur);
        m_seen = 1'b1;
        m_gap = 0;
      end
      m_gap++;
    end
    m_prev = m_s;
  end

  task automatic mon_clear();
    obs_q.delete();
    gap_q.delete();
    m_seen = 1'b0;
    viol = 0;
    done_cnt = 0;
  endtask

  // ---------------- request table image kept by the bench
  bit          e_op [NR];
  logic [31:0] e_addr [NR];
  logic [31:0] e_data [NR];
  int          e_l [NR];
  bit          e_early [NR];

  task automatic wr_entry(input int i);
    cfg_we = 1'b1;
    cfg_idx = IW'(i);
    cfg_op = e_op[i];
    cfg_addr = e_addr[i];
    cfg_data = e_data[i];
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Random table; read expectations follow earlier writes in the same run,
  // with roughly one read in four deliberately corrupted.
  task automatic gen(input int cnt);
    logic [31:0] v;
    bit hit;
    for (int i = 0; i < NR; i++) begin
      e_op[i] = 1'($urandom_range(0, 1));
      e_addr[i] = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
      e_l[i] = $urandom_range(0, 5);
      e_early[i] = ($urandom_range(0, 3) == 0);
      if (e_op[i]) begin
        e_data[i] = $urandom;
      end else begin
        v = mdl_rd(e_addr[i]);
        hit = 1'b0;
        for (int j = i - 1; j >= 0; j--) begin
          if (!hit && e_op[j] && e_addr[j] == e_addr[i] && j < cnt) begin
            v = e_data[j];
            hit = 1'b1;
          end
        end
        if ($urandom_range(0, 3) == 0) v = v ^ (32'h1 << $urandom_range(0, 31));
        e_data[i] = v;
      end
    end
  endtask

  // Load the table, run cnt requests, compare against the model.
  task automatic exec(input string nm, input int cnt, input bit interfere);
    int     exp_mm;
    longint exp_stall;
    bit     seen;
    int     n;
    exp_mm = 0;
    exp_stall = 0;
    seen = 1'b0;
    for (int i = 0; i < NR; i++) wr_entry(i);
    for (int i = 0; i < cnt; i++) begin
      lat_q.push_back(e_l[i]);
      early_q.push_back(e_early[i]);
      exp_stall += longint'(e_l[i]) + longint'(e_early[i]);
      if (e_op[i] == OP_WRITE) mdl_mem[e_addr[i]] = e_data[i];
      else if (mdl_rd(e_addr[i]) !== e_data[i]) exp_mm++;
    end
    mon_clear();
    cfg_count = (IW+1)'(cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done || error) begin
        seen = 1'b1;
        break;
      end
      if (interfere && c == 2) begin
        start = 1'b1;
        cfg_we = 1'b1;
        cfg_idx = IW'(cnt - 1);
        cfg_op = ~e_op[cnt - 1];
        cfg_addr = 32'hDEAD0000;
        cfg_data = 32'h0BAD0BAD;
        cfg_count = 4'd1;
      end
      if (c == 3) begin
        start = 1'b0;
        cfg_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    cfg_we = 1'b0;
    chk({nm, "_end_seen"}, 64'(seen), 64'd1);
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_error"}, 64'(error), 64'd0);
    @(negedge clk);
    chk({nm, "_busy_after"}, 64'(busy), 64'd0);
    chk({nm, "_ntxn"}, 64'(obs_q.size()), 64'(cnt));
    n = (obs_q.size() < cnt) ? obs_q.size() : cnt;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_op%0d", nm, i), 64'(obs_q[i].op), 64'(e_op[i]));
      chk($sformatf("%s_addr%0d", nm, i), 64'(obs_q[i].addr), 64'(e_addr[i]));
      if (e_op[i] == OP_WRITE)
        chk($sformatf("%s_wdata%0d", nm, i), 64'(obs_q[i].data), 64'(e_data[i]));
      chk($sformatf("%s_dur%0d", nm, i), 64'(obs_q[i].dur), 64'(e_l[i] + 2));
    end
    chk({nm, "_ngap"}, 64'(gap_q.size()), 64'(cnt > 0 ? cnt - 1 : 0));
    foreach (gap_q[i]) chk($sformatf("%s_gap%0d", nm, i), 64'(gap_q[i]), 64'd1);
    chk({nm, "_mismatch"}, 64'(mismatch_cnt), 64'(exp_mm));
    chk({nm, "_stall"}, 64'(stall_cycles), 64'(exp_stall));
    chk({nm, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({nm, "_protocol"}, 64'(viol), 64'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_addr"}, 64'(bus.address), 64'd0);
    chk({nm, "_rd"}, 64'(bus.c_read_i), 64'd0);
    chk({nm, "_wr"}, 64'(bus.c_wr_i), 64'd0);
    chk({nm, "_wdata"}, 64'(bus.wr_data), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_error"}, 64'(error), 64'd0);
    chk({nm, "_mm"}, 64'(mismatch_cnt), 64'd0);
    chk({nm, "_stall"}, 64'(stall_cycles), 64'd0);
  endtask

  initial begin
    bit seen;
    int cnt;

    // reset
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // count 0: immediate done, no strobe
    exec("cnt0", 0, 1'b0);

    // single read hit on a preloaded word
    env_mem[32'h98] = 32'h12345678;
    mdl_mem[32'h98] = 32'h12345678;
    e_op[0] = OP_READ; e_addr[0] = 32'h98; e_data[0] = 32'h12345678;
    e_l[0] = 0; e_early[0] = 1'b0;
    exec("hit", 1, 1'b0);
    chk("hit_stall_const", 64'(stall_cycles), 64'd0);
    chk("hit_mm_const", 64'(mismatch_cnt), 64'd0);

    // cold miss followed by a hit
    e_op[0] = OP_READ; e_addr[0] = 32'h80000062;
    e_data[0] = mdl_rd(32'h80000062); e_l[0] = 6; e_early[0] = 1'b0;
    e_op[1] = OP_READ; e_addr[1] = 32'h98; e_data[1] = 32'h12345678;
    e_l[1] = 0; e_early[1] = 1'b0;
    exec("miss", 2, 1'b0);
    chk("miss_stall_const", 64'(stall_cycles), 64'd6);

    // write/read mix on one line, then with one corrupted expectation
    e_op[0] = OP_WRITE; e_addr[0] = 32'h10; e_data[0] = 32'hA5A5A5A5;
    e_op[1] = OP_READ;  e_addr[1] = 32'h10; e_data[1] = 32'hA5A5A5A5;
    e_op[2] = OP_READ;  e_addr[2] = 32'h14; e_data[2] = mdl_rd(32'h14);
    e_op[3] = OP_WRITE; e_addr[3] = 32'h18; e_data[3] = 32'h5A5A5A5A;
    for (int i = 0; i < 4; i++) begin e_l[i] = i; e_early[i] = 1'b0; end
    exec("mix", 4, 1'b0);
    chk("mix_mm_const", 64'(mismatch_cnt), 64'd0);
    e_data[2] = mdl_rd(32'h14) ^ 32'h000000FF;
    exec("mixbad", 4, 1'b0);
    chk("mixbad_mm_const", 64'(mismatch_cnt), 64'd1);

    // randomized runs, with start/cfg pokes while busy
    for (int r = 0; r < 8; r++) begin
      cnt = $urandom_range(1, NR);
      gen(cnt);
      exec($sformatf("rnd%0d", r), cnt, cnt >= 3);
    end

    // busywait stuck high: timeout after TO busy edges
    e_op[0] = OP_READ; e_addr[0] = 32'h200; e_data[0] = 32'h0;
    wr_entry(0);
    stuck = 1'b1;
    mon_clear();
    cfg_count = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (error || done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("to_seen", 64'(seen), 64'd1);
    chk("to_error", 64'(error), 64'd1);
    chk("to_busy", 64'(busy), 64'd0);
    chk("to_rd", 64'(bus.c_read_i), 64'd0);
    @(negedge clk);
    stuck = 1'b0;
    chk("to_error_sticky", 64'(error), 64'd1);
    chk("to_no_done", 64'(done_cnt), 64'd0);
    chk("to_stall", 64'(stall_cycles), 64'(TO));
    chk("to_ntxn", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) chk("to_dur", 64'(obs_q[0].dur), 64'(TO));

    // reset in the middle of a miss
    e_op[0] = OP_READ; e_addr[0] = 32'h300; e_data[0] = mdl_rd(32'h300);
    wr_entry(0);
    lat_q.push_back(20);
    early_q.push_back(1'b0);
    cfg_count = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_rd_before", 64'(bus.c_read_i), 64'd1);
    chk("rst_mid_bw_before", 64'(bus.c_busywait_o), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_mid");
    reset = 1'b0;
    lat_q.delete();
    early_q.delete();
    @(negedge clk);

    // table survives reset: replay the miss entry without reloading
    lat_q.push_back(1);
    early_q.push_back(1'b0);
    mon_clear();
    cfg_count = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (done || error) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("replay_seen", 64'(seen), 64'd1);
    @(negedge clk);
    chk("replay_ntxn", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) begin
      chk("replay_addr", 64'(obs_q[0].addr), 64'h300);
      chk("replay_dur", 64'(obs_q[0].dur), 64'd3);
    end
    chk("replay_mm", 64'(mismatch_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
